// File: rtl/dram_rowcol_mux.sv
// Row/column address multiplexer for DRAM: latches a CPU address and drives timed /RAS, /CAS, /WE.
// Define DRAM_REFRESH_EN to add the periodic CAS-before-RAS refresh timer and refresh states.
module dram_rowcol_mux #(
   parameter int MUX_W   = 8,
   parameter int T_RCD   = 1,
   parameter int T_CAS   = 2,
   parameter int T_RP    = 2,
   parameter int REF_INT = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               we,
   input  logic [2*MUX_W-1:0] addr,
   input  logic               noe,
   output logic [MUX_W-1:0]   ma,
   output logic               nras,
   output logic               ncas,
   output logic               nwe,
   output logic               ack,
   output logic               busy
);

   localparam int PH_MAX  = (T_RCD > T_CAS) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                            : ((T_CAS > T_RP) ? T_CAS : T_RP);
   localparam int CNT_MAX = (REF_INT > PH_MAX) ? REF_INT : PH_MAX;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef DRAM_REFRESH_EN
   typedef enum logic [2:0] {
      S_IDLE, S_RAS, S_CAS, S_PRE, S_REF_CAS, S_REF_RAS
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_RAS, S_CAS, S_PRE
   } state_t;
`endif

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [2*MUX_W-1:0] addr_reg;
   logic               we_reg;
   logic               start;
   logic [2*MUX_W-1:0] addr_cur;
   logic [MUX_W-1:0]   ma_reg, ma_next;
   logic               nras_reg, nras_next;
   logic               ncas_reg, ncas_next;
   logic               nwe_reg, nwe_next;
   logic               ack_reg, ack_next;

`ifdef DRAM_REFRESH_EN
   logic [CNT_W-1:0]   tmr_reg;
   logic               ref_pending_reg;
   logic               ref_take;
`endif

   // Phase sequencing: cnt holds remaining cycles of the current phase minus one.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      start      = 1'b0;
`ifdef DRAM_REFRESH_EN
      ref_take   = 1'b0;
`endif
      case (state_reg)
         S_IDLE: begin
`ifdef DRAM_REFRESH_EN
            if (ref_pending_reg) begin
               state_next = S_REF_CAS;
               cnt_next   = '0;
               ref_take   = 1'b1;
            end else
`endif
            if (req) begin
               state_next = S_RAS;
               cnt_next   = CNT_W'(T_RCD - 1);
               start      = 1'b1;
            end
         end
         S_RAS: begin
            if (cnt_reg == '0) begin
               state_next = S_CAS;
               cnt_next   = CNT_W'(T_CAS - 1);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_CAS: begin
            if (cnt_reg == '0) begin
               state_next = S_PRE;
               cnt_next   = CNT_W'(T_RP - 1);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_PRE: begin
            if (cnt_reg == '0) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
`ifdef DRAM_REFRESH_EN
         S_REF_CAS: begin
            state_next = S_REF_RAS;
            cnt_next   = CNT_W'(T_CAS - 1);
         end
         S_REF_RAS: begin
            if (cnt_reg == '0) begin
               state_next = S_PRE;
               cnt_next   = CNT_W'(T_RP - 1);
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
`endif
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Strobes and ma are decoded from the next state so they come straight out of flops.
   assign addr_cur = start ? addr : addr_reg;

   always_comb begin
      nras_next = 1'b1;
      ncas_next = 1'b1;
      nwe_next  = 1'b1;
      ack_next  = 1'b0;
      ma_next   = '0;
      case (state_next)
         S_RAS: begin
            nras_next = 1'b0;
            ma_next   = addr_cur[MUX_W-1:0];
         end
         S_CAS: begin
            nras_next = 1'b0;
            ncas_next = 1'b0;
            nwe_next  = ~we_reg;
            ma_next   = addr_reg[2*MUX_W-1:MUX_W];
            ack_next  = (cnt_next == '0);
         end
         // Precharge holds whatever ma showed last: the column, or zero after a refresh.
         S_PRE: ma_next = ma_reg;
`ifdef DRAM_REFRESH_EN
         S_REF_CAS: ncas_next = 1'b0;
         S_REF_RAS: begin
            nras_next = 1'b0;
            ncas_next = 1'b0;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         ma_reg    <= '0;
         nras_reg  <= 1'b1;
         ncas_reg  <= 1'b1;
         nwe_reg   <= 1'b1;
         ack_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (start) begin
            addr_reg <= addr;
            we_reg   <= we;
         end
         ma_reg    <= ma_next;
         nras_reg  <= nras_next;
         ncas_reg  <= ncas_next;
         nwe_reg   <= nwe_next;
         ack_reg   <= ack_next;
      end
   end

`ifdef DRAM_REFRESH_EN
   // An expiry coinciding with the refresh being taken wins, so that interval is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_reg         <= CNT_W'(REF_INT - 1);
         ref_pending_reg <= 1'b0;
      end else if (tmr_reg == '0) begin
         tmr_reg         <= CNT_W'(REF_INT - 1);
         ref_pending_reg <= 1'b1;
      end else begin
         tmr_reg <= tmr_reg - CNT_W'(1);
         if (ref_take)
            ref_pending_reg <= 1'b0;
      end
   end
`endif

   assign ma   = noe ? '0 : ma_reg;
   assign nras = nras_reg;
   assign ncas = ncas_reg;
   assign nwe  = nwe_reg;
   assign ack  = ack_reg;
   assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_dram_rowcol_mux.sv
// Directed bench for dram_rowcol_mux: per-cycle strobe checks plus an ack-driven address scoreboard.
// Built with DRAM_REFRESH_EN it runs the refresh-collision scenario instead of the plain-access set.
module tb_dram_rowcol_mux;
   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic        noe;
   logic [15:0] addr;
   logic [7:0]  ma;
   logic        nras, ncas, nwe, ack, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int ack_cnt  = 0;

   typedef struct {
      logic [7:0] row;
      logic [7:0] col;
      logic       nwe;
   } exp_t;
   exp_t sb[$];

   logic [7:0] last_row, last_col;
   logic       last_nwe;

   always #5 clk = ~clk;

   dram_rowcol_mux #(
      .MUX_W(8), .T_RCD(1), .T_CAS(2), .T_RP(2), .REF_INT(16)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .noe(noe),
      .ma(ma), .nras(nras), .ncas(ncas), .nwe(nwe), .ack(ack), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobes(input string tag, input logic e_nras, input logic e_ncas,
                          input logic e_nwe, input logic e_ack, input logic e_busy,
                          input logic [7:0] e_ma);
      check($sformatf("%s.nras", tag), 32'(nras), 32'(e_nras));
      check($sformatf("%s.ncas", tag), 32'(ncas), 32'(e_ncas));
      check($sformatf("%s.nwe",  tag), 32'(nwe),  32'(e_nwe));
      check($sformatf("%s.ack",  tag), 32'(ack),  32'(e_ack));
      check($sformatf("%s.busy", tag), 32'(busy), 32'(e_busy));
      check($sformatf("%s.ma",   tag), 32'(ma),   32'(e_ma));
      $display("%0t %s nras=%b ncas=%b nwe=%b ack=%b busy=%b ma=%h",
               $time, tag, nras, ncas, nwe, ack, busy, ma);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: remember what ma showed in each phase, compare on ack.
   always @(negedge clk) begin
      if (!rst) begin
         if (!nras && ncas) last_row = ma;
         if (!nras && !ncas) begin
            last_col = ma;
            last_nwe = nwe;
         end
         if (ack) begin
            ack_cnt++;
            check("sb.ack_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("sb.row", 32'(last_row), 32'(e.row));
               check("sb.col", 32'(last_col), 32'(e.col));
               check("sb.nwe", 32'(last_nwe), 32'(e.nwe));
               $display("%0t ack row=%h col=%h nwe=%b", $time, last_row, last_col, last_nwe);
            end
         end
      end
   end

   // One full access with default timing; addr/we are scrambled after RAS to show they are ignored.
   task automatic do_access(input string tag, input logic [15:0] a, input logic w, input logic n);
      logic [7:0] r, c;
      exp_t       e;
      r = n ? 8'h00 : a[7:0];
      c = n ? 8'h00 : a[15:8];
      e.row = r;
      e.col = c;
      e.nwe = ~w;
      sb.push_back(e);
      noe  = n;
      addr = a;
      we   = w;
      req  = 1'b1;
      tick(); strobes($sformatf("%s_ras", tag), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, r);
      if (n) begin
         noe = 1'b0;
         #1 check($sformatf("%s_noe_release", tag), 32'(ma), 32'(a[7:0]));
         noe = 1'b1;
         #1 check($sformatf("%s_noe_force", tag), 32'(ma), 32'd0);
      end
      addr = ~a;
      we   = ~w;
      tick(); strobes($sformatf("%s_cas1", tag), 1'b0, 1'b0, ~w, 1'b0, 1'b1, c);
      tick(); strobes($sformatf("%s_cas2", tag), 1'b0, 1'b0, ~w, 1'b1, 1'b1, c);
      tick(); req = 1'b0;
      strobes($sformatf("%s_pre1", tag), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, c);
      tick(); strobes($sformatf("%s_pre2", tag), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, c);
      tick(); strobes($sformatf("%s_idle", tag), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      noe = 1'b0;
   endtask

   initial begin
      int a0;
      exp_t e;
      rst  = 1'b1;
      req  = 1'b0;
      we   = 1'b0;
      noe  = 1'b0;
      addr = 16'h0000;
      tick();
      tick();
      strobes("reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;

`ifdef DRAM_REFRESH_EN
      // Timer starts at 15, so the 16th edge after release sets ref_pending.
      for (int i = 0; i < 16; i++) tick();
      addr = 16'hBEEF;
      we   = 1'b0;
      req  = 1'b1;
      e.row = 8'hEF; e.col = 8'hBE; e.nwe = 1'b1;
      sb.push_back(e);
      a0 = ack_cnt;
      tick(); strobes("ref_cas",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      tick(); strobes("ref_ras1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      tick(); strobes("ref_ras2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      tick(); strobes("ref_pre1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      tick(); strobes("ref_pre2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0 | 1'b1, 8'h00);
      tick(); strobes("ref_idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tick(); strobes("ref_acc_ras",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hEF);
      tick(); strobes("ref_acc_cas1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hBE);
      tick(); strobes("ref_acc_cas2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBE);
      tick(); req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("ref_ack_once", 32'(ack_cnt - a0), 32'd1);
`else
      tick();
      strobes("idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

      do_access("rd",  16'hA55A, 1'b0, 1'b0);
      do_access("wr",  16'h1234, 1'b1, 1'b0);
      do_access("noe", 16'hC3E7, 1'b1, 1'b1);

      // Reset in the middle of a write: strobes release at once, no ack, access discarded.
      a0   = ack_cnt;
      addr = 16'h5678;
      we   = 1'b1;
      req  = 1'b1;
      tick(); strobes("rst_ras", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h78);
      tick(); strobes("rst_cas", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h56);
      rst = 1'b1;
      #1 strobes("rst_async", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      req = 1'b0;
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      check("rst_no_ack", 32'(ack_cnt), 32'(a0));
      do_access("post_rst", 16'h9ABC, 1'b0, 1'b0);

      // req held through ack: second access starts at the IDLE edge with the then-current addr/we.
      a0   = ack_cnt;
      addr = 16'h0F0F;
      we   = 1'b0;
      req  = 1'b1;
      e.row = 8'h0F; e.col = 8'h0F; e.nwe = 1'b1;
      sb.push_back(e);
      tick(); strobes("b2b_ras1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F);
      addr = 16'h7E81;
      we   = 1'b1;
      e.row = 8'h81; e.col = 8'h7E; e.nwe = 1'b0;
      sb.push_back(e);
      tick(); strobes("b2b_cas1a", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F);
      tick(); strobes("b2b_cas1b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F);
      tick(); strobes("b2b_pre1a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F);
      tick(); strobes("b2b_pre1b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F);
      tick(); strobes("b2b_idle",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tick(); strobes("b2b_ras2",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
      tick(); strobes("b2b_cas2a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E);
      tick(); strobes("b2b_cas2b", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E);
      tick(); req = 1'b0;
      tick(); tick();
      strobes("b2b_idle2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      strobes("b2b_stay_idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      check("b2b_two_acks", 32'(ack_cnt - a0), 32'd2);
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
